// File: rtl/perip_bus_master.sv
// Core-side initiator for the peripheral bus: turns CPU load/store requests into
// word-wide tristate bus cycles, using read-modify-write for sub-word stores.
module perip_bus_master #(
  parameter logic [31:0] PERIP_BASE = 32'hffff0000,
  parameter logic [31:0] PERIP_MASK = 32'hffffff00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        req_err;
  logic [31:0] rd_shift;

  always_comb begin
    req_err = ((req_addr & PERIP_MASK) != PERIP_BASE) || (req_size == 2'd3) ||
              (req_size == 2'd1 && req_addr[0]) ||
              (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    rd_shift = mem_data >> {addr_q, 3'b000};

    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wbuf_d       = wbuf_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        addr_d  = req_addr[1:0];
        size_d  = req_size;
        wdata_d = req_wdata[15:0];
        if (req_err) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else if (req_we && req_size == 2'd2) begin
          state_d    = WR;
          wbuf_d     = req_wdata;
          mem_we_d   = 1'b1;
          mem_addr_d = {req_addr[31:2], 2'b00};
        end else begin
          state_d    = RD;
          mem_addr_d = {req_addr[31:2], 2'b00};
        end
      end
      RD: if (we_q) begin
        // merge the stored lane into the word the responder just returned
        wbuf_d = mem_data;
        if (size_q == 2'd0) wbuf_d[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
        else                wbuf_d[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        state_d  = WR;
        mem_we_d = 1'b1;
      end else begin
        state_d      = RESP;
        mem_addr_d   = 32'h0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        case (size_q)
          2'd0:    resp_rdata_d = {24'h0, rd_shift[7:0]};
          2'd1:    resp_rdata_d = {16'h0, rd_shift[15:0]};
          default: resp_rdata_d = rd_shift;
        endcase
      end
      WR: begin
        state_d      = RESP;
        mem_we_d     = 1'b0;
        mem_addr_d   = 32'h0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
      default: if (resp_ready) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= 2'b00;
      size_q       <= 2'b00;
      wdata_q      <= 16'h0;
      wbuf_q       <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wbuf_q       <= wbuf_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = rst && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_we_q ? wbuf_q : 32'bz;

endmodule

// File: tb/tb_perip_bus_master.sv
// Bench for perip_bus_master: a transaction-level model predicts every cycle of
// bus and response activity; a small register-file responder sits on the bus.
module tb_perip_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr;
  wire  [31:0] mem_data;
  logic        init_mem = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perip_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // responder: 64 words decoded from addr[7:2], combinational read
  logic [31:0] regs [64];
  assign mem_data = mem_we ? 32'bz : regs[mem_addr[7:2]];
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 64; i++) regs[i] <= 32'h9e3779b9 * (i + 1);
    else if (mem_we) regs[mem_addr[7:2]] <= mem_data;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [64];

  function automatic exp_t mk(logic we, logic [31:0] a, logic [31:0] d,
                              logic rv, logic [31:0] rd, logic er);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.rv = rv; e.rdata = rd; e.err = er;
    return e;
  endfunction

  task automatic accept(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd);
    logic [7:0]  b [4];
    logic [31:0] wa, word, res;
    int          o;
    bit          bad;
    wa  = {a[31:2], 2'b00};
    o   = int'(a[1:0]);
    bad = ((a & 32'hffffff00) != 32'hffff0000) || sz == 3 ||
          (sz == 1 && (o % 2) != 0) || (sz == 2 && o != 0);
    word = model[a[7:2]];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    if (bad) q.push_back(mk(0, 0, 0, 1, 0, 1));
    else if (!we) begin
      if (sz == 0)      res = {24'h0, b[o]};
      else if (sz == 1) res = {16'h0, b[o+1], b[o]};
      else              res = word;
      q.push_back(mk(0, wa, 0, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 1, res, 0));
    end else if (sz == 2) begin
      q.push_back(mk(1, wa, wd, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 1, 0, 0));
    end else begin
      b[o] = wd[7:0];
      if (sz == 1) b[o+1] = wd[15:8];
      q.push_back(mk(0, wa, 0, 0, 0, 0));
      q.push_back(mk(1, wa, {b[3], b[2], b[1], b[0]}, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 1, 0, 0));
    end
  endtask

  // compare process: checks outputs each cycle, then advances the model to the next edge
  initial begin
    exp_t e;
    for (int i = 0; i < 64; i++) model[i] = 32'h9e3779b9 * (i + 1);
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        chk("idle", {mem_we, mem_addr, resp_valid, req_ready}, {1'b0, 32'h0, 1'b0, rst});
      end else begin
        e = q[0];
        chk("cycle", {mem_we, mem_addr, resp_valid, req_ready}, {e.we, e.addr, e.rv, 1'b0});
        if (e.we) chk("wdata", mem_data, e.data);
        if (e.rv) chk("resp", {resp_rdata, resp_err}, {e.rdata, e.err});
      end
      if (!rst) begin
        if (q.size() > 0 && q[0].we) model[q[0].addr[7:2]] = q[0].data;
        q.delete();
      end else if (q.size() > 0) begin
        if (!q[0].rv || resp_ready) begin
          if (q[0].we) model[q[0].addr[7:2]] = q[0].data;
          void'(q.pop_front());
        end
      end else if (req_valid) begin
        accept(req_we, req_addr, req_size, req_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // presents a request and returns 1 time unit after the edge that accepted it
  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #1;
    repeat (2) step();
    @(negedge clk);
    chk("reset_state", {mem_we, mem_addr, resp_valid, resp_rdata, resp_err, req_ready}, '0);
    step();
    rst = 1'b1; init_mem = 1'b0;
    step();

    // word store
    issue(1, 32'hffff0038, 2, 32'h3);
    @(negedge clk); chk("ws_bus", {mem_we, mem_addr, mem_data}, {1'b1, 32'hffff0038, 32'h3});
    @(negedge clk); chk("ws_resp", {resp_valid, resp_err, resp_rdata}, {1'b1, 1'b0, 32'h0});
    step();

    // word store then word load
    issue(1, 32'hffff0034, 2, 32'h10);
    step();
    issue(0, 32'hffff0034, 2, 32'h0);
    @(negedge clk); chk("wl_rd", {mem_we, mem_addr}, {1'b0, 32'hffff0034});
    @(negedge clk); chk("wl_resp", {resp_valid, resp_rdata}, {1'b1, 32'h10});
    step();

    // byte RMW then half load
    issue(1, 32'hffff0034, 2, 32'h11223344);
    step();
    issue(1, 32'hffff0035, 0, 32'hAB);
    @(negedge clk); chk("rmw_rd", {mem_we, mem_addr}, {1'b0, 32'hffff0034});
    @(negedge clk); chk("rmw_wr", {mem_we, mem_addr, mem_data}, {1'b1, 32'hffff0034, 32'h1122AB44});
    @(negedge clk); chk("rmw_resp", {resp_valid, mem_we}, {1'b1, 1'b0});
    step();
    issue(0, 32'hffff0036, 1, 32'h0);
    @(negedge clk);
    @(negedge clk); chk("hl_resp", resp_rdata, 32'h00001122);
    step();

    // errors: misaligned half, out-of-window word
    issue(1, 32'hffff0035, 1, 32'h5555);
    @(negedge clk); chk("err_half", {resp_valid, resp_err, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 32'h0});
    step();
    issue(0, 32'h00001000, 2, 32'h0);
    @(negedge clk); chk("err_win", {resp_valid, resp_err, resp_rdata, mem_we, mem_addr}, {2'b11, 32'h0, 1'b0, 32'h0});
    step();

    // response back-pressure with a queued request
    resp_ready = 1'b0;
    issue(0, 32'hffff0038, 2, 32'h0);
    @(negedge clk);
    @(negedge clk); chk("bp_first", {resp_valid, resp_rdata}, {1'b1, 32'h3});
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hffff0034; req_size = 2;
    repeat (3) begin
      @(negedge clk); chk("bp_hold", {resp_valid, resp_rdata, req_ready, mem_we}, {1'b1, 32'h3, 1'b0, 1'b0});
    end
    @(posedge clk); #1; resp_ready = 1'b1;
    issue(0, 32'hffff0034, 2, 32'h0);
    @(negedge clk); chk("bp_next", {mem_we, mem_addr}, {1'b0, 32'hffff0034});
    step(); step();

    // reset during the RD of a byte RMW
    issue(1, 32'hffff0040, 2, 32'hCAFEF00D);
    step();
    issue(1, 32'hffff0041, 0, 32'h55);
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hffff0040; req_size = 2;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); chk("rst_idle", {mem_we, mem_addr, resp_valid, req_ready}, {1'b0, 32'h0, 1'b0, 1'b1});
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); chk("rst_accept", {mem_we, mem_addr}, {1'b0, 32'hffff0040});
    @(negedge clk); chk("rst_unchanged", {resp_valid, resp_rdata}, {1'b1, 32'hCAFEF00D});
    step();

    // randomized traffic including back-pressure and sporadic resets
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      rst        = ($urandom_range(0, 99) != 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_we     = $urandom_range(0, 1) == 1;
      req_size   = 2'($urandom_range(0, 3));
      a          = (($urandom_range(0, 9) != 0) ? 32'hffff0000 : $urandom) | {24'h0, 8'($urandom)};
      if ($urandom_range(0, 1) == 1) a[1:0] = (req_size == 2'd1) ? {a[1], 1'b0} : 2'b00;
      req_addr   = a;
      req_wdata  = $urandom;
      resp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perip_bus_master.md
# perip_bus_master

Core-side initiator for the embedded SoC peripheral bus: it accepts load/store requests from the CPU over a valid/ready handshake and drives the shared tristate peripheral bus (mem_we, mem_addr, mem_data). Peripherals such as the timer sit on the other end of that bus as responders. The block converts byte, halfword and word accesses into word-wide bus cycles, with read-modify-write for sub-word stores. It flags out-of-window and misaligned requests without touching the bus.

## Interface
- PERIP_BASE, 32'hffff0000, base of the peripheral address window
- PERIP_MASK, 32'hffffff00, address bits compared against PERIP_BASE; in-window iff (req_addr & PERIP_MASK) == PERIP_BASE
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when both high
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as an error
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when both high
- resp_rdata  out  32  load data, right-aligned, zero-extended; 0 for stores and errors
- resp_err  out  1  misaligned, size 3, or out-of-window request
- mem_we  out  1  bus write strobe
- mem_addr  out  32  bus word address (bits [1:0] always 0)
- mem_data  inout  32  bus data; driven only while mem_we = 1, otherwise high-Z

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready = 1 (0 while rst = 0). On req_valid, latch req_we, req_addr, req_size and req_wdata.
  - Error (out of window, size 3, half with addr[0] = 1, or word with addr[1:0] != 0): go to RESP with resp_err = 1 and resp_rdata = 0. No bus cycle is issued.
  - Load: go to RD.
  - Word store: go to WR with wbuf = req_wdata.
  - Byte or half store: go to RD for read-modify-write.
- RD (one cycle): mem_addr = {addr[31:2], 2'b00}, mem_we = 0, mem_data released. The combinational responder value on mem_data is captured at the closing edge.
  - Load: resp_rdata = (word >> 8*addr[1:0]) masked to 8 or 16 bits by size (word: unchanged). Next state RESP.
  - RMW: wbuf = captured word with the addressed byte or half lane replaced by req_wdata. Next state WR.
- WR (one cycle): mem_we = 1, mem_addr = word address, mem_data = wbuf. Next state RESP.
- RESP: resp_valid = 1, resp_rdata and resp_err held stable until resp_ready = 1, then IDLE. No new request is accepted in RESP.
- Outside RD/WR: mem_we = 0, mem_addr = 32'h0, mem_data = Z.
- Lane select: byte lane = addr[1:0]; half lane = addr[1].

## Timing
- Reset (rst = 0 at an edge): state IDLE, mem_we = 0, mem_addr = 0, mem_data = Z, resp_valid = 0, resp_rdata = 0, resp_err = 0. req_ready = 0 while rst = 0.
- Request accepted at edge N. Response latency, counted from the edge that latches the request to resp_valid high:
  - error: resp_valid high after edge N (1 cycle)
  - load or word store: bus cycle N..N+1, resp_valid after edge N+1 (2 cycles)
  - sub-word store: RD N..N+1, WR N+1..N+2, resp_valid after edge N+2 (3 cycles)
- Exactly one bus cycle per load or word store and two per sub-word store. mem_we is never high for more than one consecutive cycle.
- Throughput: the next request is accepted in the IDLE cycle after the response handshake (at most one outstanding request).
- Reset mid-transaction: abandon the transaction; no response, no further bus cycle. The bus is idle after the reset edge. An RMW cut after RD writes nothing.
- resp_ready held low: the response holds indefinitely, bus stays idle, req_ready = 0.

## Test plan
- Word store 32'h3 to 32'hffff0038 -> cycle after accept has mem_we = 1, mem_addr = 32'hffff0038, mem_data = 32'h3; next cycle resp_valid = 1, resp_err = 0, resp_rdata = 0.
- Word store 32'h10 to 32'hffff0034, then word load 32'hffff0034 -> RD cycle with mem_we = 0 and mem_data not driven by the master; resp_rdata = 32'h10 two cycles after accept.
- Responder word 32'h11223344 at 32'hffff0034; byte store 32'hAB to 32'hffff0035 -> RD, then WR with mem_data = 32'h1122AB44; resp_valid 3 cycles after accept. Then half load 32'hffff0036 -> resp_rdata = 32'h00001122.
- Half store to 32'hffff0035, and word load from 32'h00001000 -> resp_err = 1 one cycle after accept; mem_we stays 0 and mem_addr stays 0 throughout.
- Load with resp_ready held low 3 cycles -> resp_valid and resp_rdata held stable, req_ready = 0, and a queued req_valid is not accepted until after the handshake.
- Sub-word store with rst driven low during RD -> next cycle mem_we = 0, resp_valid = 0, target register unchanged, and a request is accepted in the first cycle after rst returns high.
